lut_mux_engine: RTL and testbench
=================================

// Module: lut_mux_engine
// PURPOSE
//   Parametrised, registered truth-table function generator: IN_W-bit vector in, OUT_W-bit code out,
//   function held in a run-time loadable table instead of hard-wired mux data inputs.
//   Sits between combinational code-converter users and downstream logic.
//   Valid/ready on both sides; table reloadable in service; saturating evaluation counter.
// PARAMETERS
//   IN_W        3        input vector width; table depth = 2**IN_W entries
//   OUT_W       2        output code width = table entry width
//   TBL_INIT    16'h3796 reset table contents, entry k at bits [OUT_W*k +: OUT_W]
//                        (default = legacy 3-in/2-out converter: x0..x7 -> 2,1,1,2,3,1,3,0)
//   AUTO_ARM    1        1: leave reset in ARMED; 0: leave reset in UNCONF
//   CNT_W       16       evaluation counter width
// PORTS
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous, active-high reset
//   cfg_we      in   1            table write strobe
//   cfg_addr    in   IN_W         table entry index
//   cfg_data    in   OUT_W        table entry value
//   cfg_commit  in   1            end of load; arm the engine
//   armed       out  1            1 when state == ARMED
//   in_valid    in   1            in_x valid
//   in_ready    out  1            engine accepts in_x this cycle
//   in_x        in   IN_W         input vector
//   out_valid   out  1            out_y valid
//   out_ready   in   1            consumer accepts out_y this cycle
//   out_y       out  OUT_W        table[in_x] registered
//   eval_cnt    out  CNT_W        accepted evaluations since reset/commit, saturating
// BEHAVIOUR
//   Reset (rst=1 at clk edge): table <= TBL_INIT; state <= AUTO_ARM ? ARMED : UNCONF;
//     out_valid=0, out_y=0, eval_cnt=0. Reset mid-transfer discards the held result.
//   States: UNCONF -> (cfg_we) LOAD; LOAD -> (cfg_commit) ARMED; ARMED -> (cfg_we) LOAD.
//     cfg_commit in UNCONF or ARMED: ignored. cfg_we and cfg_commit same cycle in LOAD:
//     write performed, then ARMED (write visible to first evaluation).
//   Table write: table[cfg_addr] <= cfg_data on any cycle cfg_we=1 (any state except under rst).
//   in_ready = (state==ARMED) & ~cfg_we & (~out_valid | out_ready); combinational.
//     cfg_we and in_valid same cycle in ARMED: config wins, input not accepted.
//   Accept = in_valid & in_ready. Latency 1: out_y <= table[in_x] (pre-write table contents),
//     out_valid <= 1 on the edge after accept.
//   out_valid falls when out_ready=1 and no new accept; accept with out_ready=1 gives
//     back-to-back results, full throughput 1/clk. out_y/out_valid stable while out_valid & ~out_ready.
//   A result already held when leaving ARMED stays valid until consumed (not flushed).
//   eval_cnt += 1 per accept; holds at 2**CNT_W-1; cleared to 0 on the cfg_commit
//     edge that enters ARMED.
//   Width rules: cfg_addr/in_x index directly, no out-of-range entries; IN_W >= 1, OUT_W >= 1.
// STRUCTURE
//   Shared package/include lut_mux_pkg: state encoding (UNCONF=2'd0, LOAD=2'd1, ARMED=2'd2),
//     table size function tbl_bits(IN_W,OUT_W) = OUT_W << IN_W.
//   Sub-module lut_mux_read: combinational 2**IN_W:1 OUT_W-bit mux (flat table, index -> entry);
//     top holds table regs, FSM, handshake, output register, counter.
// TESTING
//   1 Defaults, reset then stream x=0..7 with out_ready=1 -> out_y 2,1,1,2,3,1,3,0 one cycle
//     after each accept, out_valid continuous, eval_cnt=8.
//   2 Backpressure: out_ready=0 for 3 cycles after x=4 accepted -> out_y=3 held, in_ready=0,
//     next x=6 accepted only on out_ready=1 cycle, no loss/duplication.
//   3 Reload: in ARMED write addr 5 data 2 with in_valid=1 -> no accept that cycle, armed=0;
//     commit -> eval_cnt=0, x=5 now gives out_y=2.
//   4 AUTO_ARM=0, IN_W=4, OUT_W=3: in_ready=0 after reset; load 16 entries table[k]=k%8,
//     commit -> x=13 gives 5; cfg_commit alone in UNCONF leaves armed=0.
//   5 Saturation, CNT_W=3: 10 accepts -> eval_cnt stays 7.
//   6 rst asserted while out_valid=1 & out_ready=0 -> next cycle out_valid=0, out_y=0,
//     table back to TBL_INIT (x=3 -> 2).

Source files
------------

// File: rtl/lut_mux_pkg.sv
// Shared definitions for the loadable truth-table engine: FSM state encoding
// and the size of the flattened table.
package lut_mux_pkg;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        ARMED  = 2'd2
    } state_e;

    function automatic int tbl_bits(input int in_w, input int out_w);
        return out_w << in_w;
    endfunction

endpackage

// File: rtl/lut_mux_read.sv
// Combinational table read: selects one OUT_W-bit entry of the flat table by index.
module lut_mux_read
    import lut_mux_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2
) (
    input  logic [tbl_bits(IN_W, OUT_W)-1:0] tbl,
    input  logic [IN_W-1:0]                  idx,
    output logic [OUT_W-1:0]                 y
);

    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] entry [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry[gi] = tbl[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign y = entry[idx];

endmodule

// File: rtl/lut_mux_engine.sv
// Registered truth-table function generator with a run-time loadable table,
// valid/ready on both sides and a saturating evaluation counter.
module lut_mux_engine
    import lut_mux_pkg::*;
#(
    parameter int                              IN_W     = 3,
    parameter int                              OUT_W    = 2,
    parameter logic [tbl_bits(IN_W, OUT_W)-1:0] TBL_INIT = (tbl_bits(IN_W, OUT_W))'(16'h3796),
    parameter bit                              AUTO_ARM = 1'b1,
    parameter int                              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_commit,
    output logic             armed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic [CNT_W-1:0] eval_cnt
);

    localparam int TBL_W = tbl_bits(IN_W, OUT_W);

    state_e             state_q, state_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_y_q, out_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   rd_y;
    logic               accept;

    // Reads the registered table, so an evaluation never sees a same-cycle write.
    lut_mux_read #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_read (
        .tbl (tbl_q),
        .idx (in_x),
        .y   (rd_y)
    );

    assign in_ready = (state_q == ARMED) & ~cfg_we & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCONF:  if (cfg_we)     state_d = LOAD;
            LOAD:    if (cfg_commit) state_d = ARMED;
            ARMED:   if (cfg_we)     state_d = LOAD;
            default:                 state_d = UNCONF;
        endcase
    end

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we) begin
            tbl_d[int'(cfg_addr)*OUT_W +: OUT_W] = cfg_data;
        end
    end

    // A held result survives leaving ARMED; it only drops once consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_y_d     = rd_y;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LOAD && cfg_commit) begin
            cnt_d = '0;
        end else if (accept && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= AUTO_ARM ? ARMED : UNCONF;
            tbl_q       <= TBL_INIT;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign armed     = (state_q == ARMED);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign eval_cnt  = cnt_q;

endmodule

// File: tb/tb_lut_mux_engine.sv
// Scoreboard bench: default-configured engine plus a wide, unarmed, short-counter one.
module tb_lut_mux_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: defaults ----------------
    logic        a_rst = 1'b1, a_cfg_we = 1'b0, a_cfg_commit = 1'b0;
    logic [2:0]  a_cfg_addr = '0, a_in_x = '0;
    logic [1:0]  a_cfg_data = '0;
    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_armed, a_in_ready, a_out_valid;
    logic [1:0]  a_out_y;
    logic [15:0] a_eval_cnt;

    lut_mux_engine u_a (
        .clk(clk), .rst(a_rst), .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr),
        .cfg_data(a_cfg_data), .cfg_commit(a_cfg_commit), .armed(a_armed),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y),
        .eval_cnt(a_eval_cnt)
    );

    // ---------------- DUT B: 4-in/3-out, unarmed, 3-bit counter ----------------
    logic        b_rst = 1'b1, b_cfg_we = 1'b0, b_cfg_commit = 1'b0;
    logic [3:0]  b_cfg_addr = '0, b_in_x = '0;
    logic [2:0]  b_cfg_data = '0;
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_armed, b_in_ready, b_out_valid;
    logic [2:0]  b_out_y;
    logic [2:0]  b_eval_cnt;

    lut_mux_engine #(.IN_W(4), .OUT_W(3), .AUTO_ARM(1'b0), .CNT_W(3)) u_b (
        .clk(clk), .rst(b_rst), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
        .cfg_data(b_cfg_data), .cfg_commit(b_cfg_commit), .armed(b_armed),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
        .eval_cnt(b_eval_cnt)
    );

    // ---------------- reference models and scoreboards ----------------
    localparam logic [1:0] A_INIT [8] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
    logic [1:0]  a_model [8];
    logic [2:0]  b_model [16];
    logic [47:0] b_init_v;
    logic [1:0]  a_q [$];
    logic [2:0]  b_q [$];

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) check_val("a_unexpected_out", 32'(a_out_y), 32'hffff_ffff);
            else check_val("a_scoreboard", 32'(a_out_y), 32'(a_q.pop_front()));
        end
        if (a_rst) begin
            a_q.delete();
            a_model = A_INIT;
        end else begin
            if (a_in_valid && a_in_ready) a_q.push_back(a_model[a_in_x]);
            if (a_cfg_we) a_model[a_cfg_addr] = a_cfg_data;
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) check_val("b_unexpected_out", 32'(b_out_y), 32'hffff_ffff);
            else check_val("b_scoreboard", 32'(b_out_y), 32'(b_q.pop_front()));
        end
        if (b_rst) begin
            b_q.delete();
            b_init_v = 48'h3796;
            for (int k = 0; k < 16; k++) b_model[k] = b_init_v[3*k +: 3];
        end else begin
            if (b_in_valid && b_in_ready) b_q.push_back(b_model[b_in_x]);
            if (b_cfg_we) b_model[b_cfg_addr] = b_cfg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state and default stream
        tick();
        check_val("a_rst_out_valid", 32'(a_out_valid), 0);
        check_val("a_rst_out_y", 32'(a_out_y), 0);
        check_val("a_rst_eval_cnt", 32'(a_eval_cnt), 0);
        check_val("a_rst_armed", 32'(a_armed), 1);
        check_val("b_rst_armed", 32'(b_armed), 0);
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_out_ready = 1'b1;
        for (int x = 0; x < 8; x++) begin
            a_in_valid = 1'b1;
            a_in_x     = 3'(x);
            tick();
            check_val("a_stream_valid", 32'(a_out_valid), 1);
            check_val("a_stream_y", 32'(a_out_y), 32'(A_INIT[x]));
        end
        a_in_valid = 1'b0;
        tick();
        check_val("a_stream_cnt", 32'(a_eval_cnt), 8);

        // 2: backpressure after x=4
        a_in_valid = 1'b1;
        a_in_x     = 3'd4;
        tick();
        a_out_ready = 1'b0;
        a_in_x      = 3'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("a_bp_in_ready", 32'(a_in_ready), 0);
            check_val("a_bp_hold_y", 32'(a_out_y), 3);
            check_val("a_bp_hold_valid", 32'(a_out_valid), 1);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        check_val("a_bp_release_ready", 32'(a_in_ready), 1);
        tick();
        a_in_valid = 1'b0;
        tick();
        check_val("a_bp_cnt", 32'(a_eval_cnt), 10);

        // 3: reload in service; config beats input
        a_in_valid = 1'b1;
        a_in_x     = 3'd5;
        a_cfg_we   = 1'b1;
        a_cfg_addr = 3'd5;
        a_cfg_data = 2'd2;
        #1;
        check_val("a_cfg_blocks_input", 32'(a_in_ready), 0);
        tick();
        a_cfg_we = 1'b0;
        #1;
        check_val("a_load_armed", 32'(a_armed), 0);
        check_val("a_load_in_ready", 32'(a_in_ready), 0);
        a_in_valid   = 1'b0;
        a_cfg_commit = 1'b1;
        tick();
        a_cfg_commit = 1'b0;
        check_val("a_commit_armed", 32'(a_armed), 1);
        check_val("a_commit_cnt", 32'(a_eval_cnt), 0);
        a_in_valid = 1'b1;
        a_in_x     = 3'd5;
        tick();
        a_in_valid = 1'b0;
        check_val("a_reload_y", 32'(a_out_y), 2);
        tick();

        // 6: reset while holding an unconsumed result
        a_in_valid = 1'b1;
        a_in_x     = 3'd0;
        tick();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        tick();
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check_val("a_rst2_out_valid", 32'(a_out_valid), 0);
        check_val("a_rst2_out_y", 32'(a_out_y), 0);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_x      = 3'd3;
        tick();
        check_val("a_rst2_x3", 32'(a_out_y), 2);
        a_in_x = 3'd5;
        tick();
        check_val("a_rst2_x5", 32'(a_out_y), 1);
        a_in_valid = 1'b0;
        tick();

        // 4: unarmed wide engine
        b_in_valid  = 1'b1;
        b_in_x      = 4'd13;
        b_out_ready = 1'b1;
        #1;
        check_val("b_unconf_in_ready", 32'(b_in_ready), 0);
        b_in_valid   = 1'b0;
        b_cfg_commit = 1'b1;
        tick();
        b_cfg_commit = 1'b0;
        check_val("b_commit_ignored", 32'(b_armed), 0);
        for (int k = 0; k < 16; k++) begin
            b_cfg_we     = 1'b1;
            b_cfg_addr   = 4'(k);
            b_cfg_data   = 3'(k % 8);
            b_cfg_commit = (k == 15);
            tick();
        end
        b_cfg_we     = 1'b0;
        b_cfg_commit = 1'b0;
        check_val("b_armed_after_load", 32'(b_armed), 1);
        check_val("b_cnt_after_commit", 32'(b_eval_cnt), 0);
        b_in_valid = 1'b1;
        b_in_x     = 4'd13;
        tick();
        check_val("b_x13", 32'(b_out_y), 5);

        // 5: counter saturation (already one accept)
        for (int k = 0; k < 10; k++) begin
            b_in_x = 4'(k);
            tick();
            if (k == 5) check_val("b_cnt_reach_max", 32'(b_eval_cnt), 7);
        end
        b_in_valid = 1'b0;
        tick();
        check_val("b_cnt_saturated", 32'(b_eval_cnt), 7);

        tick();
        tick();
        check_val("a_queue_drained", 32'(a_q.size()), 0);
        check_val("b_queue_drained", 32'(b_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
